// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial sequencer for a 4-bit arithmetic unit. It walks a W-bit operation
// through the unit one nibble per cycle and chains the carry through a register.
module alu_nibble_sequencer #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [3:0]             op_sel,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
  output logic [3:0]             alu_s,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic                   alu_cin,
  input  logic [3:0]             alu_f,
  input  logic                   alu_cout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   res_f,
  output logic                   res_cout,
  output logic                   res_zero,
  output logic                   busy
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q;
  logic [3:0]     sel_q;
  logic [W-1:0]   a_q, b_q, res_q;
  logic           cin_q, carry_q;
  logic           accept, step;
  logic [3:0]     nib_a, nib_b;

  // Operand nibble selection driven purely from registered state
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (k_q == KW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    step        = 1'b0;
    busy        = 1'b0;
    res_valid   = 1'b0;
    alu_s       = '0;
    alu_a       = '0;
    alu_b       = '0;
    alu_cin     = 1'b0;
    start_ready = (state_q == IDLE) || ((state_q == DONE) && res_ready);
    accept      = start_valid && start_ready;
    case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
      end
      RUN: begin
        step    = 1'b1;
        busy    = 1'b1;
        alu_s   = sel_q;
        alu_a   = nib_a;
        alu_b   = nib_b;
        alu_cin = (k_q == '0) ? cin_q : carry_q;
        if (k_q == K_LAST) state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = start_valid ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q     <= '0;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      res_q   <= '0;
    end else if (accept) begin
      k_q   <= '0;
      sel_q <= op_sel;
      a_q   <= op_a;
      b_q   <= op_b;
      cin_q <= op_cin;
    end else if (step) begin
      for (int unsigned i = 0; i < NIBBLES; i++) begin
        if (k_q == KW'(i)) res_q[4*i +: 4] <= alu_f;
      end
      carry_q <= alu_cout;
      k_q     <= (k_q == K_LAST) ? '0 : k_q + KW'(1);
    end
  end

  // The carry register holds the final nibble carry once RUN completes
  assign res_f    = res_q;
  assign res_cout = carry_q;
  assign res_zero = (res_q == '0);

endmodule
